// File: rtl/i2c_read_sequencer.sv
`timescale 1ns / 1ps
// Burst read sequencer in front of an I2C master receiver.
// Issues one byte read at a time and buffers results in a FWFT FIFO.
module i2c_read_sequencer #(
    parameter int DEPTH       = 8,
    parameter int GAP_CYC     = 1000,
    parameter int TIMEOUT_CYC = 32768
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [6:0]               i_device_addr,
    input  logic [7:0]               i_start_addr,
    input  logic [7:0]               i_len,
    output logic                     o_i2c_recv_en,
    output logic [6:0]               o_device_addr,
    output logic [7:0]               o_data_addr,
    input  logic [7:0]               i_read_data,
    input  logic                     i_done_flag,
    output logic                     o_rd_valid,
    output logic [7:0]               o_rd_data,
    input  logic                     i_rd_ready,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic                     o_busy,
    output logic                     o_seq_done,
    output logic                     o_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [15:0] GAP_LIM = 16'(GAP_CYC);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, GAP} state_t;

    state_t        state, state_nx;
    logic [15:0]   gap_cnt, to_cnt;
    logic [7:0]    remaining;
    logic          done_q;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, done_rise, start_ok;
    logic          seq_done_nx, timeout_nx;

    assign done_rise     = i_done_flag & ~done_q;
    assign start_ok      = i_start & (i_len != 8'd0);
    assign o_rd_valid    = (o_fifo_count != '0);
    assign pop           = o_rd_valid & i_rd_ready;
    assign o_rd_data     = o_rd_valid ? mem[rd_ptr] : 8'h00;
    assign o_busy        = (state != IDLE);
    assign o_i2c_recv_en = (state == ISSUE);

    // The last byte returns straight to IDLE so done/busy settle together.
    always_comb begin
        state_nx    = state;
        push        = 1'b0;
        seq_done_nx = 1'b0;
        timeout_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nx = GAP;
            end
            GAP: begin
                if (!i_done_flag && gap_cnt >= GAP_LIM && o_fifo_count < FULL)
                    state_nx = ISSUE;
            end
            ISSUE: begin
                if (done_rise) begin
                    push = 1'b1;
                    if (remaining == 8'd1) begin
                        state_nx    = IDLE;
                        seq_done_nx = 1'b1;
                    end else begin
                        state_nx = CAPTURE;
                    end
                end else if (to_cnt >= TO_LAST) begin
                    state_nx   = IDLE;
                    timeout_nx = 1'b1;
                end
            end
            CAPTURE: state_nx = GAP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            done_q        <= 1'b0;
            o_seq_done    <= 1'b0;
            o_timeout     <= 1'b0;
            o_device_addr <= '0;
            o_data_addr   <= '0;
            remaining     <= '0;
            gap_cnt       <= '0;
            to_cnt        <= '0;
        end else begin
            state      <= state_nx;
            done_q     <= i_done_flag;
            o_seq_done <= seq_done_nx;
            o_timeout  <= timeout_nx;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        o_device_addr <= i_device_addr;
                        o_data_addr   <= i_start_addr;
                        remaining     <= i_len;
                        gap_cnt       <= GAP_LIM;
                    end
                end
                GAP: begin
                    if (gap_cnt != 16'hFFFF) gap_cnt <= gap_cnt + 16'd1;
                    to_cnt <= '0;
                end
                ISSUE: begin
                    if (to_cnt != 16'hFFFF) to_cnt <= to_cnt + 16'd1;
                    if (push) begin
                        o_data_addr <= o_data_addr + 8'd1;
                        remaining   <= remaining - 8'd1;
                    end
                end
                CAPTURE: gap_cnt <= '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= i_read_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                o_fifo_count <= o_fifo_count + CNT_ONE;
            else if (pop && !push)
                o_fifo_count <= o_fifo_count - CNT_ONE;
        end
    end

endmodule

// File: tb/tb_i2c_read_sequencer.sv
`timescale 1ns / 1ps
// Scoreboard bench for i2c_read_sequencer with a behavioural
// I2C master model and randomized commands/backpressure.
module tb_i2c_read_sequencer;

    localparam int DEPTH = 8;
    localparam int GAP   = 1000;
    localparam int TMO   = 1000;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic [6:0] i_device_addr;
    logic [7:0] i_start_addr;
    logic [7:0] i_len;
    logic       o_i2c_recv_en;
    logic [6:0] o_device_addr;
    logic [7:0] o_data_addr;
    logic [7:0] i_read_data;
    logic       i_done_flag;
    logic       o_rd_valid;
    logic [7:0] o_rd_data;
    logic       i_rd_ready;
    logic [3:0] o_fifo_count;
    logic       o_busy;
    logic       o_seq_done;
    logic       o_timeout;

    i2c_read_sequencer #(
        .DEPTH(DEPTH), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .i_device_addr(i_device_addr), .i_start_addr(i_start_addr),
        .i_len(i_len), .o_i2c_recv_en(o_i2c_recv_en),
        .o_device_addr(o_device_addr), .o_data_addr(o_data_addr),
        .i_read_data(i_read_data), .i_done_flag(i_done_flag),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .i_rd_ready(i_rd_ready), .o_fifo_count(o_fifo_count),
        .o_busy(o_busy), .o_seq_done(o_seq_done), .o_timeout(o_timeout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [14:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    int exp_done = 0, exp_to = 0, seen_done = 0, seen_to = 0;
    int burst_txn = 0, cur_stall = -1;
    int lat_min = 1, lat_max = 300, ready_mode = 1;
    bit fixed_en = 0;
    logic [7:0] fixed_val = 8'h00;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    // Byte the master model returns for a given device/register
    function automatic logic [7:0] model(input logic [6:0] dev,
                                         input logic [7:0] a);
        if (fixed_en) return fixed_val;
        return a ^ 8'h5A ^ {1'b0, dev ^ 7'h50};
    endfunction

    // Master receiver model: responds to en after a random latency
    initial begin : master
        int lat;
        int waited;
        bit stall;
        i_done_flag = 1'b0;
        i_read_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (o_i2c_recv_en) begin
                if (exp_addr.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL master_addr: unexpected txn %0h/%0h",
                             o_device_addr, o_data_addr);
                end else begin
                    check("master_addr", {o_device_addr, o_data_addr},
                          exp_addr.pop_front());
                end
                stall = (burst_txn == cur_stall);
                burst_txn++;
                lat = $urandom_range(lat_max, lat_min);
                waited = 1;
                while (o_i2c_recv_en && (stall || waited < lat) &&
                       waited < 5000) begin
                    @(posedge clk); #1;
                    waited++;
                end
                if (o_i2c_recv_en) begin
                    i_read_data = model(o_device_addr, o_data_addr);
                    i_done_flag = 1'b1;
                    repeat ($urandom_range(1, 6)) @(posedge clk);
                    #1;
                    i_done_flag = 1'b0;
                end
            end
        end
    end

    initial begin : ready_drv
        i_rd_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 2) i_rd_ready = 1'($urandom_range(0, 1));
            else i_rd_ready = (ready_mode == 1);
        end
    end

    // Output monitor: pops scoreboard on every accepted byte
    bit en_prev = 0, low_ok = 0;
    int en_run = 0, low_run = 0, last_run = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev = 0; low_ok = 0; en_run = 0; low_run = 0;
        end else begin
            if (o_rd_valid && i_rd_ready) begin
                if (exp_data.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rd_data: unexpected byte %0h", o_rd_data);
                end else begin
                    check("rd_data", o_rd_data, exp_data.pop_front());
                end
            end
            if (o_i2c_recv_en)
                check("en_with_room", o_fifo_count < DEPTH, 1);
            if (o_i2c_recv_en && !en_prev) begin
                if (low_ok) check("gap_ge_min", low_run >= GAP, 1);
                en_run = 0;
            end
            if (!o_i2c_recv_en && en_prev) begin
                last_run = en_run;
                low_run = 0;
                low_ok = 1;
            end
            if (o_i2c_recv_en) en_run++;
            else low_run++;
            if (!o_busy) low_ok = 0;
            if (o_timeout) begin
                seen_to++;
                check("timeout_en_cycles", last_run, TMO);
                check("timeout_busy", o_busy, 0);
            end
            if (o_seq_done) begin
                seen_done++;
                check("seq_done_busy", o_busy, 0);
            end
            en_prev = o_i2c_recv_en;
        end
    end

    // Reference model of a command: addresses seen and bytes streamed
    task automatic run_cmd(input logic [6:0] dev, input logic [7:0] addr,
                           input logic [7:0] len, input int stall);
        int naddr, nbytes;
        logic [7:0] a;
        bit aborts;
        aborts = (stall >= 0 && stall < int'(len));
        naddr  = aborts ? stall + 1 : int'(len);
        nbytes = aborts ? stall : int'(len);
        for (int i = 0; i < naddr; i++) begin
            a = addr + 8'(i);
            exp_addr.push_back({dev, a});
        end
        for (int i = 0; i < nbytes; i++) begin
            a = addr + 8'(i);
            exp_data.push_back(model(dev, a));
        end
        if (len != 0) begin
            if (aborts) exp_to++;
            else exp_done++;
        end
        cur_stall = stall;
        burst_txn = 0;
        i_device_addr = dev;
        i_start_addr = addr;
        i_len = len;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("start_busy", o_busy, len != 0);
        check("start_en_low", o_i2c_recv_en, 0);
        @(posedge clk); #1;
        check("start_en", o_i2c_recv_en, len != 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((o_busy || o_rd_valid || i_done_flag) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", {o_busy, o_rd_valid, i_done_flag}, 0);
    endtask

    initial begin : stim
        int n;
        rst_n = 1'b0;
        i_start = 1'b0;
        i_device_addr = '0;
        i_start_addr = '0;
        i_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", o_i2c_recv_en, 0);
        check("rst_busy", o_busy, 0);
        check("rst_valid", o_rd_valid, 0);
        check("rst_count", o_fifo_count, 0);
        check("rst_pulses", {o_seq_done, o_timeout}, 0);
        check("rst_addr", {o_device_addr, o_data_addr}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single read with fixed data and fixed latency
        fixed_en = 1; fixed_val = 8'hA5;
        lat_min = 200; lat_max = 200; ready_mode = 1;
        run_cmd(7'h50, 8'h10, 8'd1, -1);
        n = 0;
        while (!i_done_flag && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        @(posedge clk); #2;
        check("cap_en_low", o_i2c_recv_en, 0);
        check("cap_count", o_fifo_count, 1);
        check("cap_valid", o_rd_valid, 1);
        check("cap_data", o_rd_data, 8'hA5);
        check("cap_seq_done", o_seq_done, 1);
        wait_idle(3000);
        fixed_en = 0;

        // burst wrapping the register address
        lat_min = 1; lat_max = 300;
        run_cmd(7'h50, 8'hFE, 8'd4, -1);
        wait_idle(10000);

        // backpressure: FIFO fills and stalls
        ready_mode = 0;
        run_cmd(7'h2C, 8'h40, 8'd10, -1);
        n = 0;
        while (o_fifo_count != 8 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3000) @(posedge clk);
        #1;
        check("bp_count", o_fifo_count, 8);
        check("bp_en_low", o_i2c_recv_en, 0);
        check("bp_txns", burst_txn, 8);
        check("bp_busy", o_busy, 1);
        ready_mode = 2;
        wait_idle(30000);

        // timeout on the second byte
        ready_mode = 0;
        run_cmd(7'h11, 8'h80, 8'd3, 1);
        n = 0;
        while (o_busy && n < 10000) begin
            @(posedge clk); #1;
            n++;
        end
        check("to_busy_low", o_busy, 0);
        check("to_kept_count", o_fifo_count, 1);
        check("to_kept_valid", o_rd_valid, 1);
        ready_mode = 1;
        wait_idle(100);

        // zero-length command is ignored
        run_cmd(7'h22, 8'h33, 8'd0, -1);
        repeat (5) @(posedge clk);
        #1;
        check("len0_busy", o_busy, 0);
        check("len0_txns", burst_txn, 0);

        // start mid-burst is ignored
        run_cmd(7'h33, 8'h20, 8'd3, -1);
        n = 0;
        while (burst_txn < 1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        i_device_addr = 7'h7F; i_start_addr = 8'hC0; i_len = 8'd9;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_idle(10000);
        check("midstart_txns", burst_txn, 3);

        // randomized commands and consumer
        for (int k = 0; k < 5; k++) begin
            ready_mode = 2;
            run_cmd(7'($urandom), 8'($urandom), 8'($urandom_range(1, 4)), -1);
            wait_idle(20000);
        end

        // asynchronous reset mid-burst with two bytes buffered
        ready_mode = 0;
        lat_min = 50;
        run_cmd(7'h44, 8'h00, 8'd4, -1);
        n = 0;
        while (!(o_fifo_count == 2 && o_i2c_recv_en) && n < 10000) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_en", o_i2c_recv_en, 0);
        check("arst_valid", o_rd_valid, 0);
        check("arst_count", o_fifo_count, 0);
        check("arst_busy", o_busy, 0);
        exp_addr.delete();
        exp_data.delete();
        exp_done--;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 1;
        @(posedge clk); #1;
        run_cmd(7'h12, 8'h34, 8'd2, -1);
        wait_idle(10000);

        check("total_seq_done", seen_done, exp_done);
        check("total_timeout", seen_to, exp_to);
        check("left_data", exp_data.size(), 0);
        check("left_addr", exp_addr.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_read_sequencer.md
# i2c_read_sequencer

Burst controller sitting directly upstream of the I2C master receiver. It accepts a single "read N bytes from device D starting at register A" command and drives the master's enable/address inputs one byte at a time. It collects each returned byte into an internal first-word-fall-through FIFO and presents the bytes on a valid/ready stream. It enforces the inter-transaction gap and a per-byte timeout.

## Interface
- DEPTH, 8: FIFO entries (power of two, ≥2)
- GAP_CYC, 1000: minimum idle clk cycles between master transactions
- TIMEOUT_CYC, 32768: max clk cycles to wait for master done per byte (≤65535)
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  command strobe, sampled only in IDLE
- i_device_addr  in  7  target device address, latched at start
- i_start_addr  in  8  first register address, latched at start
- i_len  in  8  byte count, 1..255; 0 ⇒ command ignored
- o_i2c_recv_en  out  1  enable to master
- o_device_addr  out  7  to master
- o_data_addr  out  8  to master
- i_read_data  in  8  byte from master
- i_done_flag  in  1  master done (level)
- o_rd_valid  out  1  FIFO head valid
- o_rd_data  out  8  FIFO head byte
- i_rd_ready  in  1  consumer pops head when valid&ready
- o_fifo_count  out  $clog2(DEPTH)+1  current occupancy
- o_busy  out  1  high outside IDLE
- o_seq_done  out  1  one-cycle pulse, all bytes captured
- o_timeout  out  1  one-cycle pulse, sequence aborted

## Operation
- Reset: all outputs 0; FIFO empty; state IDLE. Reset mid-burst drops o_i2c_recv_en immediately (asynchronous) and discards the FIFO.
- FSM states: IDLE, ISSUE, CAPTURE, GAP.
- IDLE:
  - i_start=1 with i_len≠0 → latch device addr, register addr and remaining=i_len; go to GAP with gap counter preloaded to satisfied.
  - i_start during a non-IDLE state is ignored.
- GAP → ISSUE when all three hold: i_done_flag=0, gap counter ≥ GAP_CYC, o_fifo_count < DEPTH.
- Full FIFO stalls in GAP indefinitely; the master never sees en while there is no room.
- ISSUE:
  - o_i2c_recv_en=1; addresses held stable; timeout counter runs from 0.
  - A rising edge of i_done_flag (registered previous value 0) captures i_read_data → CAPTURE.
  - Counter reaching TIMEOUT_CYC-1 → en=0, o_timeout pulse, go to IDLE. Bytes already in the FIFO are retained.
- CAPTURE:
  - en=0; byte pushed to FIFO; o_data_addr increments mod 256 (0xFF→0x00); remaining decrements.
  - remaining reaches 0 → o_seq_done pulse, go to IDLE.
  - Otherwise go to GAP with the gap counter cleared.
- FIFO:
  - Simultaneous push and pop leaves the count unchanged.
  - Pop when empty is ignored.
  - Push never occurs when full, guaranteed by the GAP gating.
  - o_rd_data is don't-care when o_rd_valid=0.

## Timing
- i_start at edge T → o_busy=1 at T+1; o_i2c_recv_en=1 at T+2 (one GAP cycle).
- i_done_flag first seen high at edge T → o_i2c_recv_en=0, o_fifo_count+1, o_rd_valid=1 at T+1.
  - Same-cycle o_seq_done pulse and o_busy=0 at T+1 if this was the last byte.
- Next en assertion is no earlier than GAP_CYC cycles after CAPTURE, and never while i_done_flag is still high.
- Pop at edge T → count decrements at T+1; the new head appears at T+1.
- Timeout: en asserted for exactly TIMEOUT_CYC cycles, then o_timeout at the following cycle.
- Gap and timeout counters are 16 bits wide and saturate.

## Test plan
- Single read:
  - Stimulus: dev=0x50, addr=0x10, len=1; master model returns 0xA5 with done after 200 cycles; ready=1.
  - Response: one en pulse with addr 0x10; o_rd_data=0xA5 valid for one cycle; o_seq_done once; busy low afterwards.
- Burst with wrap:
  - Stimulus: addr=0xFE, len=4; model data = addr^0x5A.
  - Response: master sees addresses 0xFE, 0xFF, 0x00, 0x01; stream 0xA4, 0xA5, 0x5A, 0x5B; en-low gaps ≥1000 cycles.
- Backpressure:
  - Stimulus: len=10, ready=0.
  - Response: exactly 8 transactions, then count=8 and en stays low. Raising ready resumes; all 10 bytes are delivered in order.
- Timeout:
  - Stimulus: len=3; model never raises done on the second byte; TIMEOUT_CYC=1000.
  - Response: o_timeout once, en low after 1000 cycles; the first byte remains readable; no o_seq_done.
- Ignored commands:
  - Stimulus: len=0 start, then a second start issued mid-burst.
  - Response: no en, busy stays 0 for the first; the in-flight burst is unchanged and its addresses are not reloaded for the second.
- Reset mid-op:
  - Stimulus: rst_n low while en=1 with 2 bytes buffered.
  - Response: en, valid, count and busy go to 0 without waiting for clk.
